uart_frame_decoder: RTL and testbench

//  Consumer of the UART controller's RX FIFO. Hunts for framed commands, buffers and checksums the

---
 rtl/uart_frame_decoder_if.sv | 53 +++++
 rtl/uart_frame_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_decoder_if.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder_if
// Bundles every non-clock/reset signal of the UART frame decoder:
//   rx_*      read strobe / data from the UART controller RX FIFO
//   tx_*      write-lock handshake and 1-byte ACK/NAK toward the controller
//   cmd_*     accepted-frame notification (opcode, word count)
//   word_*    verified payload stream toward the systolic-array loader
//   frame_err error pulse, busy status
// master: the decoder side.  slave: the controller/loader side.
// ---------------------------------------------------------------------------
interface uart_frame_decoder_if;
   logic        rx_read;
   logic [7:0]  rx_data;
   logic        rx_data_valid;
   logic        tx_lock_req;
   logic        tx_lock_res;
   logic        tx_ready;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        cmd_valid;
   logic [7:0]  cmd_opcode;
   logic [7:0]  cmd_length;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_last;
   logic        word_ready;
   logic        frame_err;
   logic        busy;

   modport master (
      output rx_read,
      input  rx_data, rx_data_valid,
      output tx_lock_req,
      input  tx_lock_res, tx_ready,
      output tx_data, tx_data_valid,
      output cmd_valid, cmd_opcode, cmd_length,
      output word_data, word_valid, word_last,
      input  word_ready,
      output frame_err, busy
   );

   modport slave (
      input  rx_read,
      output rx_data, rx_data_valid,
      input  tx_lock_req,
      output tx_lock_res, tx_ready,
      input  tx_data, tx_data_valid,
      input  cmd_valid, cmd_opcode, cmd_length,
      input  word_data, word_valid, word_last,
      output word_ready,
      input  frame_err, busy
   );
endinterface

// File: rtl/uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// uart_frame_decoder
// Pulls bytes from the UART controller RX FIFO, hunts for frames
//   SYNC, OP, LEN, LEN*4 payload bytes, CHK   (CHK = XOR of OP, LEN, payload)
// buffers the payload, answers ACK (06) / NAK (15) through write-lock port 0,
// and after an ACK streams the buffered 32-bit words to the loader.
// Ports:
//   clock    system clock
//   reset    synchronous, active-high
//   dec_if   uart_frame_decoder_if.master (rx, tx, cmd, word stream, status)
// MAX_WORDS must be >= 2.
// ---------------------------------------------------------------------------
module uart_frame_decoder #(
   parameter int         MAX_WORDS      = 16,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
   input logic                   clock,
   input logic                   reset,
   uart_frame_decoder_if.master  dec_if
);

   localparam int         IDX_W    = $clog2(MAX_WORDS + 1);
   localparam int         BCNT_W   = IDX_W + 2;
   localparam int         AW       = $clog2(MAX_WORDS);
   localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] MAX_LEN  = 8'(MAX_WORDS);
   localparam logic [7:0] ACK_CODE = 8'h06;
   localparam logic [7:0] NAK_CODE = 8'h15;

   typedef enum logic [3:0] {
      ST_SYNC, ST_OP, ST_LEN, ST_PAY, ST_CHK,
      ST_ACK, ST_NAK, ST_ACK_DONE, ST_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic              rx_read_q, rx_read_d;
   logic              rd_pend_q;
   logic              byte_ok;
   logic [7:0]        op_q, len_q, xor_q;
   logic [BCNT_W-1:0] byte_cnt_q;
   logic [IDX_W-1:0]  rd_idx_q;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              in_frame, timed_out;
   logic              byte_last, last_word;
   logic [9:0]        pay_last;
   logic              tx_fire, hs;
   logic              err_d, frame_err_q, cmd_valid_q;
   logic [7:0]        cmd_opcode_q, cmd_length_q;
   logic [31:0]       word_q;
   logic [AW-1:0]     wr_addr, rd_addr_nxt;
   logic [31:0]       buf_mem [MAX_WORDS];

   // output-process results
   logic              tx_lock_req_o, tx_data_valid_o, word_valid_o, word_last_o, busy_o;
   logic [7:0]        tx_data_o;
   logic [31:0]       word_data_o;

   function automatic logic is_rx_state(state_t s);
      return s inside {ST_SYNC, ST_OP, ST_LEN, ST_PAY, ST_CHK};
   endfunction

   // A byte is present the cycle after a read strobe; an empty FIFO answers
   // with rx_data_valid=0 and the strobe is simply issued again.
   assign byte_ok   = rd_pend_q && dec_if.rx_data_valid;
   assign in_frame  = state_q inside {ST_OP, ST_LEN, ST_PAY, ST_CHK};
   assign timed_out = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));
   assign pay_last  = {len_q, 2'b00} - 10'd1;
   assign byte_last = (10'(byte_cnt_q) == pay_last);
   assign last_word = (8'(rd_idx_q) == len_q - 8'd1);
   // tx handshake is suppressed in a reset cycle so a reset never leaks an ACK/NAK
   assign tx_fire   = (state_q inside {ST_ACK, ST_NAK}) && dec_if.tx_lock_res
                      && dec_if.tx_ready && !reset;
   assign hs        = (state_q == ST_DRAIN) && dec_if.word_ready;
   assign wr_addr   = byte_cnt_q[AW+1:2];
   assign rd_addr_nxt = rd_idx_q[AW-1:0] + AW'(1);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock) begin
      if (reset) state_q <= ST_SYNC;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         ST_SYNC: if (byte_ok && dec_if.rx_data == SYNC_BYTE) state_d = ST_OP;
         ST_OP: begin
            if (byte_ok)        state_d = ST_LEN;
            else if (timed_out) begin state_d = ST_SYNC; err_d = 1'b1; end
         end
         ST_LEN: begin
            if (byte_ok) begin
               if (dec_if.rx_data > MAX_LEN)      begin state_d = ST_NAK; err_d = 1'b1; end
               else if (dec_if.rx_data == 8'd0)   state_d = ST_CHK;
               else                               state_d = ST_PAY;
            end else if (timed_out) begin
               state_d = ST_SYNC; err_d = 1'b1;
            end
         end
         ST_PAY: begin
            if (byte_ok)        begin if (byte_last) state_d = ST_CHK; end
            else if (timed_out) begin state_d = ST_SYNC; err_d = 1'b1; end
         end
         ST_CHK: begin
            if (byte_ok) begin
               if (dec_if.rx_data == xor_q) state_d = ST_ACK;
               else                         begin state_d = ST_NAK; err_d = 1'b1; end
            end else if (timed_out) begin
               state_d = ST_SYNC; err_d = 1'b1;
            end
         end
         ST_ACK:      if (tx_fire) state_d = ST_ACK_DONE;
         ST_NAK:      if (tx_fire) state_d = ST_SYNC;
         // lock released here; cmd_valid and the first word follow next cycle
         ST_ACK_DONE: state_d = (len_q == 8'd0) ? ST_SYNC : ST_DRAIN;
         ST_DRAIN:    if (hs && last_word) state_d = ST_SYNC;
         default:     state_d = ST_SYNC;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      tx_lock_req_o   = 1'b0;
      tx_data_o       = 8'h00;
      tx_data_valid_o = 1'b0;
      word_valid_o    = 1'b0;
      word_last_o     = 1'b0;
      word_data_o     = 32'h0;
      busy_o          = (state_q != ST_SYNC);
      case (state_q)
         ST_ACK: begin
            tx_lock_req_o   = 1'b1;
            tx_data_o       = ACK_CODE;
            tx_data_valid_o = tx_fire;
         end
         ST_NAK: begin
            tx_lock_req_o   = 1'b1;
            tx_data_o       = NAK_CODE;
            tx_data_valid_o = tx_fire;
         end
         ST_DRAIN: begin
            word_valid_o = 1'b1;
            word_last_o  = last_word;
            word_data_o  = word_q;
         end
         default: ;
      endcase
   end

   // next read strobe: only toward a byte-consuming state, never back-to-back
   assign rx_read_d = is_rx_state(state_d) && !rx_read_q;

   always_comb begin
      to_cnt_d = '0;
      if (in_frame) begin
         if (byte_ok)         to_cnt_d = '0;
         else if (!timed_out) to_cnt_d = to_cnt_q + TO_W'(1);
         else                 to_cnt_d = to_cnt_q;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_read_q    <= 1'b0;
         rd_pend_q    <= 1'b0;
         op_q         <= '0;
         len_q        <= '0;
         xor_q        <= '0;
         byte_cnt_q   <= '0;
         rd_idx_q     <= '0;
         to_cnt_q     <= '0;
         frame_err_q  <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_opcode_q <= '0;
         cmd_length_q <= '0;
         word_q       <= '0;
      end else begin
         rx_read_q   <= rx_read_d;
         rd_pend_q   <= rx_read_q;
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= err_d;
         cmd_valid_q <= (state_q == ST_ACK_DONE);
         if (byte_ok) begin
            case (state_q)
               ST_SYNC: begin xor_q <= '0; byte_cnt_q <= '0; end
               ST_OP:   begin op_q <= dec_if.rx_data; xor_q <= xor_q ^ dec_if.rx_data; end
               ST_LEN:  begin len_q <= dec_if.rx_data; xor_q <= xor_q ^ dec_if.rx_data; end
               ST_PAY: begin
                  xor_q <= xor_q ^ dec_if.rx_data;
                  if (!byte_last) byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
               end
               default: ;
            endcase
         end
         if (state_q == ST_ACK_DONE) begin
            cmd_opcode_q <= op_q;
            cmd_length_q <= len_q;
            rd_idx_q     <= '0;
            word_q       <= buf_mem[0];
         end
         // registered buffer read: fetch the following word on each handshake
         if (hs && !last_word) begin
            rd_idx_q <= rd_idx_q + IDX_W'(1);
            word_q   <= buf_mem[rd_addr_nxt];
         end
      end
   end

   // payload buffer, one byte lane written per accepted payload byte
   always_ff @(posedge clock) begin
      if (byte_ok && state_q == ST_PAY)
         buf_mem[wr_addr][{byte_cnt_q[1:0], 3'b000} +: 8] <= dec_if.rx_data;
   end

   assign dec_if.rx_read       = rx_read_q;
   assign dec_if.tx_lock_req   = tx_lock_req_o;
   assign dec_if.tx_data       = tx_data_o;
   assign dec_if.tx_data_valid = tx_data_valid_o;
   assign dec_if.cmd_valid     = cmd_valid_q;
   assign dec_if.cmd_opcode    = cmd_opcode_q;
   assign dec_if.cmd_length    = cmd_length_q;
   assign dec_if.word_data     = word_data_o;
   assign dec_if.word_valid    = word_valid_o;
   assign dec_if.word_last     = word_last_o;
   assign dec_if.frame_err     = frame_err_q;
   assign dec_if.busy          = busy_o;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_decoder
// Directed frames from a table plus hand-written sequences for stalls,
// timeout and mid-operation reset. MAX_WORDS=4, TIMEOUT_CYCLES=40.
// ---------------------------------------------------------------------------
module tb_uart_frame_decoder;
   localparam int TMO = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_frame_decoder_if bus ();

   uart_frame_decoder #(.MAX_WORDS(4), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
      .clock  (clk),
      .reset  (rst),
      .dec_if (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- controller FIFO model ----------------
   logic [7:0] fifo_q[$];
   always @(posedge clk) begin
      bus.rx_data_valid <= 1'b0;
      if (bus.rx_read && fifo_q.size() > 0) begin
         bus.rx_data       <= fifo_q.pop_front();
         bus.rx_data_valid <= 1'b1;
      end
   end

   // ---------------- monitor ----------------
   logic [7:0]  tx_log[$], op_log[$], len_log[$];
   logic [31:0] w_log[$];
   logic        wl_log[$];
   int          err_cnt = 0;
   int          cyc = 0;
   int          tx_cyc = -100;
   logic        stall_prev = 1'b0;
   logic [31:0] stall_data = '0;

   always @(negedge clk) begin
      cyc++;
      if (bus.tx_data_valid) begin
         tx_log.push_back(bus.tx_data);
         tx_cyc = cyc;
      end
      if (bus.frame_err) err_cnt++;
      if (bus.cmd_valid) begin
         op_log.push_back(bus.cmd_opcode);
         len_log.push_back(bus.cmd_length);
         check("cmd_latency", 64'(cyc - tx_cyc), 64'd2);
         if (bus.cmd_length != 8'd0) check("first_word_with_cmd", 64'(bus.word_valid), 64'd1);
      end
      if (bus.word_valid && bus.word_ready) begin
         w_log.push_back(bus.word_data);
         wl_log.push_back(bus.word_last);
      end
      if (stall_prev) begin
         check("stall_valid", 64'(bus.word_valid), 64'd1);
         check("stall_data", 64'(bus.word_data), 64'(stall_data));
      end
      stall_prev = bus.word_valid && !bus.word_ready;
      stall_data = bus.word_data;
      if (bus.tx_lock_req || bus.word_valid) check("no_rx_read_tx_drain", 64'(bus.rx_read), 64'd0);
   end

   task automatic clear_logs();
      tx_log.delete(); op_log.delete(); len_log.delete();
      w_log.delete(); wl_log.delete();
      err_cnt = 0;
   endtask

   task automatic check_outputs_zero(input string nm);
      check(nm, {bus.rx_read, bus.tx_lock_req, bus.tx_data, bus.tx_data_valid, bus.cmd_valid,
                 bus.cmd_opcode, bus.cmd_length, bus.word_data, bus.word_valid, bus.word_last,
                 bus.frame_err, bus.busy}, 64'd0);
   endtask

   task automatic wait_idle(input string nm);
      int stable = 0;
      int n = 0;
      while (stable < 4 && n < 3000) begin
         @(negedge clk);
         n++;
         if (fifo_q.size() == 0 && !bus.busy && !bus.rx_data_valid) stable++;
         else stable = 0;
      end
      check({"idle_", nm}, 64'(stable >= 4), 64'd1);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      int                 nb;
      logic [39:0][7:0]   b;
      int                 ntx;
      logic [1:0][7:0]    tx;
      int                 nerr;
      int                 ncmd;
      logic [7:0]         op;
      logic [7:0]         len;
      int                 nw;
      logic [3:0][31:0]   w;
   } vec_t;

   localparam int NV = 6;
   vec_t vt [NV];

   task automatic set_frame(input int i, input logic [7:0] f[$]);
      vt[i].nb = f.size();
      for (int k = 0; k < f.size(); k++) vt[i].b[k] = f[k];
   endtask

   task automatic run_vec(input int i);
      string nm;
      nm = $sformatf("v%0d", i);
      clear_logs();
      for (int k = 0; k < vt[i].nb; k++) fifo_q.push_back(vt[i].b[k]);
      wait_idle(nm);
      check({nm, "_ntx"}, 64'(tx_log.size()), 64'(vt[i].ntx));
      for (int k = 0; k < vt[i].ntx && k < tx_log.size(); k++)
         check($sformatf("%s_tx%0d", nm, k), 64'(tx_log[k]), 64'(vt[i].tx[k]));
      check({nm, "_err"}, 64'(err_cnt), 64'(vt[i].nerr));
      check({nm, "_ncmd"}, 64'(op_log.size()), 64'(vt[i].ncmd));
      if (vt[i].ncmd > 0 && op_log.size() > 0) begin
         check({nm, "_op"}, 64'(op_log[0]), 64'(vt[i].op));
         check({nm, "_len"}, 64'(len_log[0]), 64'(vt[i].len));
      end
      check({nm, "_nw"}, 64'(w_log.size()), 64'(vt[i].nw));
      for (int k = 0; k < vt[i].nw && k < w_log.size(); k++) begin
         check($sformatf("%s_w%0d", nm, k), 64'(w_log[k]), 64'(vt[i].w[k]));
         check($sformatf("%s_last%0d", nm, k), 64'(wl_log[k]), 64'(k == vt[i].nw - 1));
      end
      $display("vector %0d: %0d bytes, tx=%0d cmd=%0d words=%0d err=%0d",
               i, vt[i].nb, tx_log.size(), op_log.size(), w_log.size(), err_cnt);
   endtask

   initial begin
      logic [7:0] fq[$];
      int n;

      for (int i = 0; i < NV; i++) vt[i] = '0;
      // 0: good frame; checksum = 01^02^11^22^33^44^55^66^77^88 = 8B
      fq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
      set_frame(0, fq);
      vt[0].ntx = 1; vt[0].tx[0] = 8'h06; vt[0].ncmd = 1; vt[0].op = 8'h01; vt[0].len = 8'h02;
      vt[0].nw = 2; vt[0].w[0] = 32'h44332211; vt[0].w[1] = 32'h88776655;
      // 1: same frame, wrong checksum
      fq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      set_frame(1, fq);
      vt[1].ntx = 1; vt[1].tx[0] = 8'h15; vt[1].nerr = 1;
      // 2: LEN=5 > 4, garbage, then good frame (chk 03^01^DE^AD^BE^EF = 20)
      fq = '{8'hA5, 8'h07, 8'h05, 8'h12, 8'h34, 8'h56,
             8'hA5, 8'h03, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h20};
      set_frame(2, fq);
      vt[2].ntx = 2; vt[2].tx[0] = 8'h15; vt[2].tx[1] = 8'h06; vt[2].nerr = 1;
      vt[2].ncmd = 1; vt[2].op = 8'h03; vt[2].len = 8'h01; vt[2].nw = 1; vt[2].w[0] = 32'hEFBEADDE;
      // 3: leading garbage, LEN=0
      fq = '{8'h3C, 8'hA5, 8'h09, 8'h00, 8'h09};
      set_frame(3, fq);
      vt[3].ntx = 1; vt[3].tx[0] = 8'h06; vt[3].ncmd = 1; vt[3].op = 8'h09; vt[3].len = 8'h00;
      // 4: LEN=MAX_WORDS, payload 00..0F (XOR 0), chk 02^04 = 06
      fq = '{8'hA5, 8'h02, 8'h04};
      for (int k = 0; k < 16; k++) fq.push_back(8'(k));
      fq.push_back(8'h06);
      set_frame(4, fq);
      vt[4].ntx = 1; vt[4].tx[0] = 8'h06; vt[4].ncmd = 1; vt[4].op = 8'h02; vt[4].len = 8'h04;
      vt[4].nw = 4; vt[4].w[0] = 32'h03020100; vt[4].w[1] = 32'h07060504;
      vt[4].w[2] = 32'h0B0A0908; vt[4].w[3] = 32'h0F0E0D0C;
      // 5: sync byte as opcode and payload data, chk A5^01 = A4
      fq = '{8'hA5, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA4};
      set_frame(5, fq);
      vt[5].ntx = 1; vt[5].tx[0] = 8'h06; vt[5].ncmd = 1; vt[5].op = 8'hA5; vt[5].len = 8'h01;
      vt[5].nw = 1; vt[5].w[0] = 32'hA5A5A5A5;

      bus.rx_data       = 8'h00;
      bus.rx_data_valid = 1'b0;
      bus.tx_lock_res   = 1'b1;
      bus.tx_ready      = 1'b1;
      bus.word_ready    = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs_zero("reset_outputs");
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i);

      // timeout after A5,01 with FIFO empty
      clear_logs();
      fifo_q.push_back(8'hA5); fifo_q.push_back(8'h01);
      n = 0;
      while (err_cnt == 0 && n < 300) begin @(negedge clk); n++; end
      check("timeout_err_seen", 64'(err_cnt), 64'd1);
      check("timeout_window", 64'(n >= TMO && n <= TMO + 20), 64'd1);
      @(negedge clk);
      check("timeout_busy", 64'(bus.busy), 64'd0);
      repeat (10) @(negedge clk);
      check("timeout_no_tx", 64'(tx_log.size()), 64'd0);
      check("timeout_err_once", 64'(err_cnt), 64'd1);
      $display("timeout: frame_err after %0d cycles", n);

      // word_ready pattern 1-0-0-1 during drain
      clear_logs();
      for (int k = 0; k < vt[0].nb; k++) fifo_q.push_back(vt[0].b[k]);
      n = 0;
      while (!bus.word_valid && n < 300) begin @(negedge clk); n++; end
      check("stall_word_valid_seen", 64'(bus.word_valid), 64'd1);
      @(posedge clk); #1 bus.word_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 bus.word_ready = 1'b1;
      wait_idle("stall");
      check("stall_nw", 64'(w_log.size()), 64'd2);
      if (w_log.size() == 2) begin
         check("stall_w0", 64'(w_log[0]), 64'h44332211);
         check("stall_w1", 64'(w_log[1]), 64'h88776655);
         check("stall_last0", 64'(wl_log[0]), 64'd0);
         check("stall_last1", 64'(wl_log[1]), 64'd1);
      end
      $display("stall: %0d handshakes", w_log.size());

      // reset in the middle of the payload
      clear_logs();
      for (int k = 0; k < vt[0].nb; k++) fifo_q.push_back(vt[0].b[k]);
      n = 0;
      while (fifo_q.size() > 6 && n < 300) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      check("midpay_busy", 64'(bus.busy), 64'd1);
      pulse_reset();
      check_outputs_zero("midpay_reset_outputs");
      #1 rst = 1'b0;
      fifo_q.delete();
      repeat (10) @(negedge clk);
      check("midpay_no_tx", 64'(tx_log.size()), 64'd0);
      $display("reset mid-payload applied");

      // reset while waiting for the write lock
      clear_logs();
      bus.tx_lock_res = 1'b0;
      for (int k = 0; k < vt[0].nb; k++) fifo_q.push_back(vt[0].b[k]);
      n = 0;
      while (!bus.tx_lock_req && n < 300) begin @(negedge clk); n++; end
      check("midack_lock_req", 64'(bus.tx_lock_req), 64'd1);
      repeat (3) @(negedge clk);
      pulse_reset();
      check_outputs_zero("midack_reset_outputs");
      #1 rst = 1'b0;
      bus.tx_lock_res = 1'b1;
      repeat (10) @(negedge clk);
      check("midack_no_tx", 64'(tx_log.size()), 64'd0);
      check("midack_no_cmd", 64'(op_log.size()), 64'd0);
      $display("reset mid-ack applied");

      // clean decode afterwards
      run_vec(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
